// File: rtl/freq_meter.sv
// freq_meter: measures period and high time of a slow monitored signal in
// system-clock cycles, and classifies the period against the standard rates
// (0.5 Hz, 1 Hz, 2 Hz, 4 Hz, 10 kHz). A missing rising edge for TIMEOUT
// cycles raises a sticky timeout flag. The flag clears on the next
// completed measurement.
//
// Pipeline (signal_i first sampled high at clock edge N):
//   edge N   : sync_q[0] captures the high level
//   edge N+1 : sync_q[1] high, rise decoded against sync_q[2]
//   edge N+2 : counts captured into cap_*_q, event strobe raised
//   edge N+3 : outputs and classification registered, valid_o high
// The timeout path uses the same two stages, so timeout_o rises exactly
// TIMEOUT cycles after the valid_o of the last rise.

module freq_meter #(
    parameter int                     COUNT_WIDTH = 28,
    parameter logic [COUNT_WIDTH-1:0] TIMEOUT     = 28'd250000000,
    parameter int                     TOL_SHIFT   = 6,
    parameter logic [COUNT_WIDTH-1:0] NOM_05HZ    = 28'd200000000,
    parameter logic [COUNT_WIDTH-1:0] NOM_1HZ     = 28'd100000000,
    parameter logic [COUNT_WIDTH-1:0] NOM_2HZ     = 28'd50000000,
    parameter logic [COUNT_WIDTH-1:0] NOM_4HZ     = 28'd25000000,
    parameter logic [COUNT_WIDTH-1:0] NOM_10KHZ   = 28'd10000
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   signal_i,
    output logic [COUNT_WIDTH-1:0] period_o,
    output logic [COUNT_WIDTH-1:0] high_o,
    output logic [4:0]             match_o,
    output logic                   valid_o,
    output logic                   timeout_o
);

    // Measurement FSM states
    localparam logic ST_IDLE    = 1'b0;
    localparam logic ST_MEASURE = 1'b1;

    localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    // True when cnt lies within nom +/- (nom >> TOL_SHIFT). The magnitude
    // difference is formed one bit wider than the counters so it never wraps.
    function automatic logic rate_match(
        input logic [COUNT_WIDTH-1:0] cnt,
        input logic [COUNT_WIDTH-1:0] nom
    );
        logic [COUNT_WIDTH:0] diff;
        logic [COUNT_WIDTH:0] tol;
        if (cnt >= nom) begin
            diff = {1'b0, cnt} - {1'b0, nom};
        end else begin
            diff = {1'b0, nom} - {1'b0, cnt};
        end
        tol = {1'b0, (nom >> TOL_SHIFT)};
        return (diff <= tol);
    endfunction

    // One-hot rate classification, bits {10kHz, 4Hz, 2Hz, 1Hz, 0.5Hz}
    function automatic logic [4:0] classify(input logic [COUNT_WIDTH-1:0] cnt);
        return {rate_match(cnt, NOM_10KHZ),
                rate_match(cnt, NOM_4HZ),
                rate_match(cnt, NOM_2HZ),
                rate_match(cnt, NOM_1HZ),
                rate_match(cnt, NOM_05HZ)};
    endfunction

    // Synchronizer / edge-detect chain: [0]=sync1, [1]=sync2, [2]=sync3
    logic [2:0]             sync_d, sync_q;
    logic                   rise_s, fall_s, level_s;

    // Measurement state and counters
    logic                   state_d, state_q;
    logic [COUNT_WIDTH-1:0] pcnt_d, pcnt_q;
    logic [COUNT_WIDTH-1:0] hcnt_d, hcnt_q;
    logic                   hfell_d, hfell_q;

    // Captured measurement and event strobes feeding the output stage
    logic [COUNT_WIDTH-1:0] cap_period_d, cap_period_q;
    logic [COUNT_WIDTH-1:0] cap_high_d, cap_high_q;
    logic                   evt_meas_d, evt_meas_q;
    logic                   evt_tmo_d, evt_tmo_q;

    // Output registers
    logic [COUNT_WIDTH-1:0] period_d, period_q;
    logic [COUNT_WIDTH-1:0] high_d, high_q;
    logic [4:0]             match_d, match_q;
    logic                   valid_d, valid_q;
    logic                   timeout_d, timeout_q;

    // Shift the asynchronous input into the synchronizer chain and decode edges
    always_comb begin
        sync_d  = {sync_q[1:0], signal_i};
        level_s = sync_q[1];
        rise_s  = sync_q[1] & ~sync_q[2];
        fall_s  = ~sync_q[1] & sync_q[2];
    end

    // Synchronizer and edge-detect flops
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Measurement FSM: runs the period/high counters and decides when a
    // measurement completes or is lost to timeout
    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        hcnt_d       = hcnt_q;
        hfell_d      = hfell_q;
        cap_period_d = cap_period_q;
        cap_high_d   = cap_high_q;
        evt_meas_d   = 1'b0;
        evt_tmo_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    // First rise only arms the block
                    state_d = ST_MEASURE;
                    pcnt_d  = CNT_ONE;
                    hcnt_d  = CNT_ONE;
                    hfell_d = 1'b0;
                end else begin
                    pcnt_d  = CNT_ZERO;
                    hcnt_d  = CNT_ZERO;
                    hfell_d = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (rise_s) begin
                    // Rise wins over a coincident timeout
                    evt_meas_d   = 1'b1;
                    cap_period_d = pcnt_q;
                    cap_high_d   = hcnt_q;
                    pcnt_d       = CNT_ONE;
                    hcnt_d       = CNT_ONE;
                    hfell_d      = 1'b0;
                end else if (pcnt_q == TIMEOUT) begin
                    evt_tmo_d = 1'b1;
                    state_d   = ST_IDLE;
                    pcnt_d    = CNT_ZERO;
                    hcnt_d    = CNT_ZERO;
                    hfell_d   = 1'b0;
                end else begin
                    // pcnt never passes TIMEOUT here, so it cannot wrap
                    pcnt_d = pcnt_q + CNT_ONE;
                    if (fall_s) begin
                        hfell_d = 1'b1;
                    end else if (level_s && !hfell_q) begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end else begin
                        hcnt_d = hcnt_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                pcnt_d  = CNT_ZERO;
                hcnt_d  = CNT_ZERO;
                hfell_d = 1'b0;
            end
        endcase
    end

    // Measurement FSM, counter and capture flops
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            pcnt_q       <= CNT_ZERO;
            hcnt_q       <= CNT_ZERO;
            hfell_q      <= 1'b0;
            cap_period_q <= CNT_ZERO;
            cap_high_q   <= CNT_ZERO;
            evt_meas_q   <= 1'b0;
            evt_tmo_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            hcnt_q       <= hcnt_d;
            hfell_q      <= hfell_d;
            cap_period_q <= cap_period_d;
            cap_high_q   <= cap_high_d;
            evt_meas_q   <= evt_meas_d;
            evt_tmo_q    <= evt_tmo_d;
        end
    end

    // Output stage: publish a captured measurement with its classification,
    // or clear the results and flag a lost signal
    always_comb begin
        period_d  = period_q;
        high_d    = high_q;
        match_d   = match_q;
        timeout_d = timeout_q;
        valid_d   = 1'b0;
        if (evt_meas_q) begin
            period_d  = cap_period_q;
            high_d    = cap_high_q;
            match_d   = classify(cap_period_q);
            valid_d   = 1'b1;
            timeout_d = 1'b0;
        end else if (evt_tmo_q) begin
            period_d  = CNT_ZERO;
            high_d    = CNT_ZERO;
            match_d   = 5'b00000;
            timeout_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output flops
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            period_q  <= CNT_ZERO;
            high_q    <= CNT_ZERO;
            match_q   <= 5'b00000;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            high_q    <= high_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_o  = period_q;
    assign high_o    = high_q;
    assign match_o   = match_q;
    assign valid_o   = valid_q;
    assign timeout_o = timeout_q;

endmodule
